// File: rtl/cut_acq_sched.sv
// Acquisition sequencer for the cut-data datapath: stretched start/stop pulses,
// word/frame counting, frame-count auto-stop and a stall watchdog.
module cut_acq_sched #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [31:0] DEF_TOTAL = 32'd1024,
  parameter logic [31:0] DEF_CUT   = 32'd512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [31:0] cfg_total,
  input  logic [31:0] cfg_cut,
  input  logic [31:0] cfg_frames,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        cut_en,
  output logic        start_en,
  output logic        stop_en,
  output logic [31:0] total_num,
  output logic [31:0] cut_num,
  output logic        busy,
  output logic        done,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic [31:0] frame_cnt
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, START_P, RUN, STOP_P} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pcnt_q;
  logic [31:0]     total_q, cut_q, frames_q, frame_cnt_q, word_q;
  logic [WD_W-1:0] wdog_q;
  logic            start_en_q, stop_en_q, busy_q, done_q, err_cfg_q, err_to_q, cmpl_q;

  logic            cfg_ok, word_wrap, frame_hit, wd_fire;
  logic [31:0]     frame_inc;
  logic [WD_W-1:0] wdog_inc;

  always_comb begin
    cfg_ok    = (total_q != '0) && (cut_q != '0) && (cut_q <= total_q);
    word_wrap = (word_q == cut_q - 32'd1);
    // Saturate rather than wrap in continuous mode.
    frame_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 32'd1;
    frame_hit = cut_en && word_wrap && (frames_q != '0) && (frame_inc == frames_q);
    wdog_inc  = wdog_q + WD_W'(1);
    wd_fire   = (TIMEOUT != 0) && !cut_en && (wdog_inc == WD_LIMIT);
  end

  // NOTE: every state and output register lives in this one clocked block and
  // uses non-blocking assignments, so all reads see the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      total_q     <= DEF_TOTAL;
      cut_q       <= DEF_CUT;
      frames_q    <= '0;
      frame_cnt_q <= '0;
      word_q      <= '0;
      wdog_q      <= '0;
      start_en_q  <= 1'b0;
      stop_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cmpl_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_wr) begin
            total_q  <= cfg_total;
            cut_q    <= cfg_cut;
            frames_q <= cfg_frames;
          end
          // Start is validated against the pre-write config registers.
          if (cmd_start && !cmd_abort) begin
            if (cfg_ok) begin
              state_q     <= START_P;
              pcnt_q      <= '0;
              start_en_q  <= 1'b1;
              busy_q      <= 1'b1;
              frame_cnt_q <= '0;
              word_q      <= '0;
              wdog_q      <= '0;
              err_cfg_q   <= 1'b0;
              err_to_q    <= 1'b0;
              cmpl_q      <= 1'b0;
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        START_P: begin
          if (cmd_abort) begin
            state_q    <= STOP_P;
            pcnt_q     <= '0;
            start_en_q <= 1'b0;
            stop_en_q  <= 1'b1;
          end else if (pcnt_q == PC_LAST) begin
            state_q    <= RUN;
            pcnt_q     <= '0;
            start_en_q <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q + PC_W'(1);
          end
        end
        RUN: begin
          if (cut_en) begin
            wdog_q <= '0;
            if (word_wrap) begin
              word_q      <= '0;
              frame_cnt_q <= frame_inc;
            end else begin
              word_q <= word_q + 32'd1;
            end
          end else if (TIMEOUT != 0) begin
            wdog_q <= wdog_inc;
          end
          // Abort outranks the watchdog, which outranks frame completion.
          if (cmd_abort || wd_fire || frame_hit) begin
            state_q   <= STOP_P;
            pcnt_q    <= '0;
            stop_en_q <= 1'b1;
          end
          if (!cmd_abort && wd_fire) err_to_q <= 1'b1;
          cmpl_q <= !cmd_abort && !wd_fire && frame_hit;
        end
        STOP_P: begin
          if (pcnt_q == PC_LAST) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            stop_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= cmpl_q;
          end else begin
            pcnt_q <= pcnt_q + PC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_en    = start_en_q;
  assign stop_en     = stop_en_q;
  assign total_num   = total_q;
  assign cut_num     = cut_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_to_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cut_acq_sched.sv
// Directed/randomized bench for cut_acq_sched; expectations come from word and
// frame arithmetic on the stimulus, checked with immediate assertions.
module tb_cut_acq_sched;

  localparam int PL = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_wr;
  logic [31:0] cfg_total, cfg_cut, cfg_frames;
  logic        cmd_start, cmd_abort, cut_en;
  logic        start_en, stop_en, busy, done, err_cfg, err_timeout;
  logic [31:0] total_num, cut_num, frame_cnt;

  int checks = 0;
  int errors = 0;

  cut_acq_sched #(
    .PULSE_LEN (PL),
    .TIMEOUT   (TO),
    .DEF_TOTAL (32'd1024),
    .DEF_CUT   (32'd512)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_wr      (cfg_wr),
    .cfg_total   (cfg_total),
    .cfg_cut     (cfg_cut),
    .cfg_frames  (cfg_frames),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .cut_en      (cut_en),
    .start_en    (start_en),
    .stop_en     (stop_en),
    .total_num   (total_num),
    .cut_num     (cut_num),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] t, input logic [31:0] c, input logic [31:0] f);
    cfg_wr = 1'b1; cfg_total = t; cfg_cut = c; cfg_frames = f;
    tick();
    cfg_wr = 1'b0;
    check("cfg_total", total_num, t);
    check("cfg_cut", cut_num, c);
  endtask

  // Issue a start and walk through the whole start pulse; ends on the first RUN cycle.
  task automatic start_run();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int i = 0; i < PL; i++) begin
      check("start_en_hi", 32'(start_en), 1);
      check("busy_start", 32'(busy), 1);
      cut_en = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      tick();
    end
    cut_en = 1'b0;
    check("start_en_lo", 32'(start_en), 0);
    check("frame_cnt_start", frame_cnt, 0);
    check("err_cfg_start", 32'(err_cfg), 0);
    check("err_timeout_start", 32'(err_timeout), 0);
  endtask

  // Called on the first observed stop_en cycle; walks the stop pulse back to idle.
  task automatic stop_run(input bit exp_done, input logic [31:0] exp_frames, input bit hold_start);
    check("stop_en_first", 32'(stop_en), 1);
    cmd_start = hold_start;
    for (int i = 1; i < PL; i++) begin
      cut_en = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      tick();
      check("stop_en_hi", 32'(stop_en), 1);
      check("done_during_stop", 32'(done), 0);
      check("frame_cnt_stop", frame_cnt, exp_frames);
    end
    cut_en = 1'b0;
    tick();
    cmd_start = 1'b0;
    check("stop_en_lo", 32'(stop_en), 0);
    check("done_pulse", 32'(done), 32'(exp_done));
    check("busy_idle", 32'(busy), 0);
    check("start_en_idle", 32'(start_en), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("busy_stays_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start_en"}, 32'(start_en), 0);
    check({tag, "_stop_en"}, 32'(stop_en), 0);
    check({tag, "_total_num"}, total_num, 1024);
    check({tag, "_cut_num"}, cut_num, 512);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err_cfg"}, 32'(err_cfg), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    int          words, gap, n;
    int unsigned cut_v, frames_v, total_v;
    bit          hit;

    reset_n = 1'b0; cfg_wr = 1'b0; cfg_total = '0; cfg_cut = '0; cfg_frames = '0;
    cmd_start = 1'b0; cmd_abort = 1'b0; cut_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Normal runs with random config and random cut_en density.
    for (int r = 0; r < 3; r++) begin
      cut_v    = $urandom_range(1, 4);
      frames_v = $urandom_range(1, 3);
      total_v  = cut_v + $urandom_range(0, 4);
      cfg(total_v, cut_v, frames_v);
      start_run();
      words = 0; gap = 0; hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
        cut_en = (gap >= 10 || $urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
        tick();
        if (cut_en) begin words++; gap = 0; end else gap++;
        check("frame_cnt_run", frame_cnt, 32'(words / int'(cut_v)));
        hit = (words == int'(cut_v * frames_v));
        check("stop_en_run", 32'(stop_en), 32'(hit));
      end
      cut_en = 1'b0;
      if (!hit) check("run_completed", 32'(words), cut_v * frames_v);
      stop_run(1'b1, frames_v, 1'b0);
    end

    // Invalid configurations are rejected and err_cfg is sticky.
    cfg(8, 9, 1);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("bad_cfg_err", 32'(err_cfg), 1);
    check("bad_cfg_busy", 32'(busy), 0);
    check("bad_cfg_start_en", 32'(start_en), 0);
    tick();
    check("bad_cfg_no_start", 32'(start_en), 0);
    if ($urandom_range(0, 1) == 1) cfg(0, $urandom_range(1, 9), 1);
    else cfg($urandom_range(1, 9), 0, 1);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("zero_cfg_err", 32'(err_cfg), 1);
    check("zero_cfg_busy", 32'(busy), 0);

    // cfg_wr with cmd_start: start judged on the old (invalid) config, new one loads.
    cfg_wr = 1'b1; cfg_total = 10; cfg_cut = 5; cfg_frames = 1; cmd_start = 1'b1;
    tick();
    cfg_wr = 1'b0; cmd_start = 1'b0;
    check("wr_start_err", 32'(err_cfg), 1);
    check("wr_start_busy", 32'(busy), 0);
    check("wr_start_total", total_num, 10);
    check("wr_start_cut", cut_num, 5);

    // Valid start clears err_cfg; abort in the second start cycle; start ignored in STOP_P.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("abort_sp_err_clr", 32'(err_cfg), 0);
    check("abort_sp_start1", 32'(start_en), 1);
    tick();
    check("abort_sp_start2", 32'(start_en), 1);
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    check("abort_sp_start_drop", 32'(start_en), 0);
    check("abort_sp_busy", 32'(busy), 1);
    stop_run(1'b0, 0, 1'b1);

    // Abort together with start in IDLE does nothing.
    cmd_start = 1'b1; cmd_abort = 1'b1; tick(); cmd_start = 1'b0; cmd_abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_start_en", 32'(start_en), 0);
    tick();
    check("abort_start_later", 32'(start_en), 0);

    // Watchdog: continuous mode, n words then silence.
    total_v = $urandom_range(3, 8);
    cfg(total_v, 3, 0);
    start_run();
    n = $urandom_range(5, 10);
    for (int i = 0; i < n; i++) begin
      cut_en = 1'b1;
      tick();
      check("wd_frame_cnt", frame_cnt, 32'((i + 1) / 3));
    end
    cut_en = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("wd_err_early", 32'(err_timeout), 0);
      check("wd_stop_early", 32'(stop_en), 0);
    end
    tick();
    check("wd_err_fire", 32'(err_timeout), 1);
    check("wd_frame_cnt_final", frame_cnt, 32'(n / 3));
    stop_run(1'b0, 32'(n / 3), 1'b0);
    check("wd_err_sticky", 32'(err_timeout), 1);

    // Abort in RUN with a simultaneous cut_en: the word still counts.
    cfg(4, 2, 0);
    start_run();
    repeat (3) begin cut_en = 1'b1; tick(); end
    check("abort_run_pre", frame_cnt, 1);
    cut_en = 1'b1; cmd_abort = 1'b1; tick(); cut_en = 1'b0; cmd_abort = 1'b0;
    check("abort_run_counted", frame_cnt, 2);
    stop_run(1'b0, 2, 1'b0);

    // Config frozen while busy, then asynchronous reset mid-run.
    total_v = $urandom_range(1, 20);
    cfg(total_v, 1, 0);
    start_run();
    repeat (5) begin cut_en = 1'b1; tick(); end
    cut_en = 1'b0;
    check("rst_frame_cnt5", frame_cnt, 5);
    cfg_wr = 1'b1; cfg_total = 77; cfg_cut = 33; cfg_frames = 9; tick(); cfg_wr = 1'b0;
    check("busy_cfg_total", total_num, total_v);
    check("busy_cfg_cut", cut_num, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_stop_en", 32'(stop_en), 0);
    check("post_reset_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cut_acq_sched.md
Name: cut_acq_sched

Overview:
Acquisition sequencer for the cut-data datapath. It holds the frame configuration (total/cut lengths) and accepts start/abort commands. It drives stretched start/stop pulses into the cut block, then counts the cut block's output words to track completed frames. It auto-stops after a programmed frame count or on a stall watchdog and reports status to the control register layer.

Parameters:
PULSE_LEN, 4, cycles start_en/stop_en are held high (>=2, so the cut block's 2-FF edge detect sees it)
TIMEOUT, 1000000, cycles without cut_en while running before a stall abort; 0 disables
DEF_TOTAL, 1024, reset value of total_num
DEF_CUT, 512, reset value of cut_num

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_wr  in  1  load cfg_total/cfg_cut/cfg_frames; honoured only in IDLE
cfg_total  in  32  frame length in words
cfg_cut  in  32  words kept per frame
cfg_frames  in  32  frames to capture; 0 = continuous
cmd_start  in  1  single-cycle start request
cmd_abort  in  1  single-cycle abort request
cut_en  in  1  word-valid strobe from the cut block output
start_en  out  1  start pulse to the cut block
stop_en  out  1  stop pulse to the cut block
total_num  out  32  registered frame length to the cut block
cut_num  out  32  registered cut length to the cut block
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
err_cfg  out  1  sticky: start rejected for bad config
err_timeout  out  1  sticky: watchdog fired
frame_cnt  out  32  frames completed in current/last run

Behaviour:
- Reset values: start_en=0, stop_en=0, total_num=DEF_TOTAL, cut_num=DEF_CUT, frames reg=0, busy=0, done=0, err_cfg=0, err_timeout=0, frame_cnt=0, word counter=0, watchdog=0, state=IDLE.
- Reset is asynchronous. An assertion mid-run returns everything to reset values immediately. No stop pulse is issued.
- All outputs are registered.
- States: IDLE, START_P, RUN, STOP_P. Pulse counter runs 0..PULSE_LEN-1.
- IDLE, cfg_wr: load all three config registers on the next edge. cfg_wr is ignored in other states.
- IDLE, cmd_start, config valid: a valid config has total_num!=0, cut_num!=0 and cut_num<=total_num.
  - Next state START_P.
  - Clear frame_cnt, word counter, watchdog, err_cfg and err_timeout.
  - start_en rises the next cycle.
- IDLE, cmd_start, config invalid: set err_cfg and stay IDLE.
- IDLE, cmd_start and cmd_abort in the same cycle: abort wins, so nothing happens.
- IDLE, cfg_wr and cmd_start in the same cycle: the start is validated against the old config registers. The new values load regardless.
- START_P: start_en=1 for exactly PULSE_LEN cycles, then go to RUN with start_en=0.
- START_P, cmd_abort: start_en drops the next cycle. Go straight to STOP_P.
- RUN, each cut_en:
  - Word counter +1 and watchdog cleared.
  - When the word counter equals cut_num-1, it wraps to 0 and frame_cnt increments.
  - If frames!=0 and the new frame_cnt==frames, go to STOP_P with a normal-completion flag set.
- RUN, cmd_abort: go to STOP_P with the completion flag clear.
- RUN, watchdog: counts cycles without cut_en. When TIMEOUT!=0 and the count reaches TIMEOUT, set err_timeout and go to STOP_P with the flag clear.
- RUN, precedence in a single cycle: abort > watchdog > frame completion. A cut_en in the same cycle as an abort is still counted.
- STOP_P: stop_en=1 for exactly PULSE_LEN cycles, then return to IDLE.
  - done pulses for one cycle on the IDLE entry cycle, only if the completion flag is set.
  - cmd_abort and cmd_start are ignored in STOP_P.
- cut_en outside RUN is ignored: no counting and no watchdog effect.
- Width rules: frame_cnt and the word counter are 32-bit. frame_cnt saturates at 0xFFFFFFFF in continuous mode. The watchdog counter is sized by $clog2(TIMEOUT+1).
- total_num and cut_num stay constant while busy.

Test Plan:
- Reset, then read outputs -> total_num=1024, cut_num=512, busy=0, start_en=stop_en=0, errors=0.
- cfg_wr total=8 cut=3 frames=2; cmd_start; 6 cut_en strobes -> start_en high for 4 cycles; frame_cnt goes 1 then 2; stop_en high for 4 cycles; done=1 for one cycle; busy=0.
- cfg cut=9 total=8, cmd_start -> err_cfg=1, state stays IDLE, start_en never asserts. A later valid start clears err_cfg.
- frames=0, TIMEOUT=16, start, 5 cut_en then silence -> err_timeout=1 exactly 16 cycles after the last cut_en, stop pulse issued, done stays 0, frame_cnt=1 (cut=3).
- Abort during START_P (cycle 2) -> start_en drops next cycle, stop_en pulses 4 cycles, done=0. Abort+start together in IDLE -> no activity.
- Assert reset_n low mid-RUN with frame_cnt=5 -> all outputs immediately at reset values. cfg_wr issued while busy leaves total_num/cut_num unchanged.
